frame_capture: RTL

//  Receive side of the panel pixel interface: samples the RGB/blank/vsync stream
//  (800x480 active, 1056x525 total) and writes one frame into pixel memory.

---
 rtl/frame_capture.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/frame_capture.sv
// frame_capture: receive side of the panel pixel interface. Registers the
// RGB/blank/vsync stream, tracks x/y inside one armed frame and queues
// {address, pixel} pairs into a small FIFO that drains over a valid/ready
// write port.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset, nothing armed
// ARMED   | waiting for the next vsync_n falling edge
// CAPTURE | counting x/y and pushing active pixels
// DRAIN   | frame ended, emptying the push stage and the FIFO
// DONE    | frame written; done held until the next arm
module frame_capture #(
  parameter int ACTIVE_COLS = 800,
  parameter int ACTIVE_ROWS = 480,
  parameter int ADDR_W      = 19,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              vsync_n,
  input  logic              blank_n,
  input  logic [7:0]        red,
  input  logic [7:0]        green,
  input  logic [7:0]        blue,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              geom_err
);

  // x saturates one past the line length so an over-long line stays detectable
  localparam int XW = $clog2(ACTIVE_COLS + 2);
  localparam int YW = $clog2(ACTIVE_ROWS + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [XW-1:0]     X_END    = XW'(ACTIVE_COLS);
  localparam logic [XW-1:0]     X_SAT    = XW'(ACTIVE_COLS + 1);
  localparam logic [YW-1:0]     Y_LAST   = YW'(ACTIVE_ROWS - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(ACTIVE_COLS);
  localparam logic [CW-1:0]     FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_CAPTURE, S_DRAIN, S_DONE
  } state_t;

  logic              vsync_q, vsync_prev_q, blank_q, blank_prev_q;
  logic [23:0]       rgb_q;
  logic              vsync_fall, blank_fall;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              overflow_q, overflow_d, geom_err_q, geom_err_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              push_vld_q, push_vld_d;
  logic [ADDR_W-1:0] push_addr_q, push_addr_d;
  logic [23:0]       push_data_q, push_data_d;

  logic [ADDR_W+23:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               fifo_pop, fifo_full, fifo_push, fifo_drop;

  // input sampling and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      vsync_prev_q <= 1'b1;
      blank_q      <= 1'b0;
      blank_prev_q <= 1'b0;
      rgb_q        <= '0;
    end else begin
      vsync_q      <= vsync_n;
      vsync_prev_q <= vsync_q;
      blank_q      <= blank_n;
      blank_prev_q <= blank_q;
      rgb_q        <= {red, green, blue};
    end
  end

  assign vsync_fall = vsync_prev_q & ~vsync_q;
  assign blank_fall = blank_prev_q & ~blank_q;

  // FIFO handshake: a pop in the same cycle frees the slot a full push needs
  assign fifo_pop  = (cnt_q != '0) & wr_ready;
  assign fifo_full = (cnt_q == FULL_CNT);
  assign fifo_push = push_vld_q & (~fifo_full | fifo_pop);
  assign fifo_drop = push_vld_q & fifo_full & ~fifo_pop;

  // next-state, position counters, push stage and status flags
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    base_d      = base_q;
    overflow_d  = overflow_q | fifo_drop;
    geom_err_d  = geom_err_q;
    push_vld_d  = 1'b0;
    push_addr_d = push_addr_q;
    push_data_d = push_data_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (arm) begin
          state_d    = S_ARMED;
          overflow_d = 1'b0;
          geom_err_d = 1'b0;
          x_d        = '0;
          y_d        = '0;
          base_d     = '0;
        end
      end
      S_ARMED: begin
        if (vsync_fall) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (vsync_fall) begin
          geom_err_d = 1'b1;
          state_d    = S_DRAIN;
        end else if (blank_q) begin
          if (x_q < X_END) begin
            push_vld_d  = 1'b1;
            push_addr_d = base_q + ADDR_W'(x_q);
            push_data_d = rgb_q;
          end
          if (x_q != X_SAT) x_d = x_q + 1'b1;
        end else if (blank_fall) begin
          if (x_q != X_END) geom_err_d = 1'b1;
          x_d    = '0;
          y_d    = y_q + 1'b1;
          base_d = base_q + COLS_A;
          if (y_q == Y_LAST) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((cnt_q == '0) && !push_vld_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // FSM register bank with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      base_q      <= '0;
      overflow_q  <= 1'b0;
      geom_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      push_vld_q  <= 1'b0;
      push_addr_q <= '0;
      push_data_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      base_q      <= base_d;
      overflow_q  <= overflow_d;
      geom_err_q  <= geom_err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      push_vld_q  <= push_vld_d;
      push_addr_q <= push_addr_d;
      push_data_q <= push_data_d;
    end
  end

  // FIFO occupancy
  always_comb begin
    cnt_d = cnt_q + CW'(fifo_push) - CW'(fifo_pop);
  end

  // FIFO storage and pointers; cleared on reset so the port reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (fifo_push) begin
        mem_q[wr_ptr_q] <= {push_addr_q, push_data_q};
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  assign wr_valid = (cnt_q != '0);
  assign wr_addr  = mem_q[rd_ptr_q][ADDR_W+23:24];
  assign wr_data  = mem_q[rd_ptr_q][23:0];
  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign geom_err = geom_err_q;

endmodule
